uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//  Frame-level controller of the UART receiver; sits directly downstream of the start-bit checker
//  and consumes its start_glitch flag, plus the parity/stop checker error flags.
//  Sequences start/data/parity/stop bits from edge/bit counts; drives every RX sub-block enable.
//  Emits a one-cycle data_valid per clean frame. Handles back-to-back frames.
// PARAMETERS
//  PRESCALE_W  6   width of Prescale and edge_cnt (legal Prescale: 8, 16, 32)
//  BIT_CNT_W   4   width of bit_cnt
//  DATA_WIDTH  8   data bits per frame
// PORTS
//  CLK             in   1           receiver oversampling clock
//  RST             in   1           asynchronous, active-low reset
//  RX_IN           in   1           serial line, synchronised upstream, idle high
//  PAR_EN          in   1           1 = frame carries parity bit
//  Prescale        in   PRESCALE_W  oversampling ratio (edges per bit)
//  edge_cnt        in   PRESCALE_W  edge index inside current bit, 0..Prescale-1
//  bit_cnt         in   BIT_CNT_W   bit index in frame: 0 start, 1..8 data, 9 parity/stop, 10 stop
//  start_glitch    in   1           registered glitch flag from start checker
//  par_err         in   1           registered parity error flag
//  stp_err         in   1           registered stop error flag
//  edge_bit_cnt_en out  1           run edge/bit counter
//  dat_samp_en     out  1           run majority-vote sampler
//  start_check_en  out  1           start-bit check strobe
//  deser_en        out  1           deserializer shift strobe
//  par_chk_en      out  1           parity check strobe
//  stp_chk_en      out  1           stop check strobe
//  data_valid      out  1           one-cycle pulse: frame received without error
//  frame_err       out  1           one-cycle pulse: parity or stop error in frame
// BEHAVIOUR
//  - States: IDLE, START, DATA, PARITY, STOP. One-hot or binary; state register only on CLK/RST.
//  - Reset (RST=0, async): state=IDLE; all outputs 0.
//  - Define CHK = (edge_cnt == Prescale-2); END = (edge_cnt == Prescale-1).
//  - IDLE: all outputs 0. RX_IN==0 -> START next cycle (counters start at 0 the following cycle).
//  - START: edge_bit_cnt_en=dat_samp_en=1; start_check_en=CHK.
//    At END: start_glitch=1 -> IDLE (counters disabled); else -> DATA.
//  - DATA: deser_en=CHK. At END with bit_cnt==DATA_WIDTH: PAR_EN ? PARITY : STOP.
//  - PARITY: par_chk_en=CHK. At END -> STOP (par_err does not abort frame).
//  - STOP: stp_chk_en=CHK. At END: data_valid=1 next cycle iff !par_err && !stp_err;
//    else frame_err=1 next cycle. data_valid and frame_err are registered, never both high.
//    Next state: RX_IN==0 at END -> START (back-to-back); else IDLE.
//  - par_err sampled only when PAR_EN=1; ignored otherwise.
//  - Strobes are single-cycle per bit; edge_bit_cnt_en/dat_samp_en level-high in all non-IDLE states.
//  - Latency: data_valid asserts 1 cycle after the last stop-bit edge (edge_cnt==Prescale-1).
//  - PAR_EN/Prescale changes mid-frame are illegal; FSM behaviour is defined only when they are held.
//  - RST mid-frame: immediate return to IDLE, all strobes/pulses cleared, no partial data_valid.
//  - Illegal state encodings recover to IDLE.
// STRUCTURE
//  - Shared package uart_rx_pkg: state enum/localparams, DATA_WIDTH, frame bit indices
//    (START_IDX=0, PAR_IDX=DATA_WIDTH+1).
//  - Single module; no sub-module. Next-state comb block, state register, registered pulse outputs.
// TESTING (Prescale=8, PAR_EN=1 unless stated; counter model drives edge_cnt/bit_cnt)
//  1 Frame 0xA5, even parity, good stop -> exactly one data_valid pulse; deser_en pulses 8 times.
//  2 RX_IN low 3 edges then high, start_glitch=1 at START END -> IDLE, no deser_en, no data_valid.
//  3 Frame with par_err=1 -> STOP still entered; frame_err pulse, no data_valid.
//  4 PAR_EN=0, frame 0x3C -> PARITY state skipped, stp_chk_en at bit 9, data_valid pulse.
//  5 Two back-to-back frames (RX_IN=0 at STOP END) -> STOP->START directly, two data_valid pulses.
//  6 RST low during DATA bit 4 -> all outputs 0 immediately; next frame after release received cleanly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame geometry
// and the frame error rule used when the stop bit has been checked.
package uart_rx_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int START_IDX      = 0;
    localparam int PAR_IDX        = DATA_WIDTH + 1;
    localparam int STOP_IDX_PAR   = DATA_WIDTH + 2;
    localparam int STOP_IDX_NOPAR = DATA_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // A parity error only counts when the frame actually carries a parity bit.
    function automatic logic frame_has_error(input logic par_en,
                                             input logic par_err,
                                             input logic stp_err);
        return (par_en && par_err) || stp_err;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Frame-level controller of the UART receiver. Walks start, data, optional
// parity and stop bits using the external edge/bit counters, strobes each
// checker once per bit and reports every completed frame with a one-cycle
// data_valid or frame_err pulse.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4,
    parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  start_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  edge_bit_cnt_en,
    output logic                  dat_samp_en,
    output logic                  start_check_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err
);

    import uart_rx_pkg::*;

    rx_state_e state_q;
    rx_state_e state_d;
    logic      data_valid_q;
    logic      data_valid_d;
    logic      frame_err_q;
    logic      frame_err_d;
    logic      edgeChk;
    logic      edgeEnd;
    logic      lastDataBit;

    // Check strobes fire one edge before the bit ends; transitions happen on the last edge.
    always_comb begin
        edgeChk     = (edge_cnt == (Prescale - PRESCALE_W'(2)));
        edgeEnd     = (edge_cnt == (Prescale - PRESCALE_W'(1)));
        lastDataBit = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));
    end

    // Next-state and next-pulse decision for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (edgeEnd) begin
                    state_d = start_glitch ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (edgeEnd && lastDataBit) begin
                    state_d = PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (edgeEnd) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (edgeEnd) begin
                    if (frame_has_error(PAR_EN, par_err, stp_err)) begin
                        frame_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                    end
                    state_d = RX_IN ? ST_IDLE : ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register together with the registered frame result pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Sub-block enables follow the current state; counters run in every non-idle state.
    always_comb begin
        edge_bit_cnt_en = 1'b0;
        dat_samp_en     = 1'b0;
        start_check_en  = 1'b0;
        deser_en        = 1'b0;
        par_chk_en      = 1'b0;
        stp_chk_en      = 1'b0;
        case (state_q)
            ST_START: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                start_check_en  = edgeChk;
            end
            ST_DATA: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                deser_en        = edgeChk;
            end
            ST_PARITY: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                par_chk_en      = edgeChk;
            end
            ST_STOP: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                stp_chk_en      = edgeChk;
            end
            default: begin
                edge_bit_cnt_en = 1'b0;
            end
        endcase
    end

    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: an edge/bit counter model feeds the FSM, a stimulus
// process drives whole frames and queues the expected outcome, and a monitor
// pops and compares whenever a frame ends (pulse or abort).
module tb_uart_rx_fsm;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int kind;
        int deser;
        int par;
        int stp;
        int start;
        int stopIdx;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       start_glitch;
    logic       par_err;
    logic       stp_err;
    logic       edge_bit_cnt_en;
    logic       dat_samp_en;
    logic       start_check_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;
    logic [3:0] lastIdx;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;

    int nDeser     = 0;
    int nPar       = 0;
    int nStp       = 0;
    int nStart     = 0;
    int stpIdxSeen = -1;
    int prevEn     = 0;
    int prevEdge   = 0;
    int prevBit    = 0;

    uart_rx_fsm #(
        .PRESCALE_W (6),
        .BIT_CNT_W  (4),
        .DATA_WIDTH (8)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .RX_IN           (RX_IN),
        .PAR_EN          (PAR_EN),
        .Prescale        (Prescale),
        .edge_cnt        (edge_cnt),
        .bit_cnt         (bit_cnt),
        .start_glitch    (start_glitch),
        .par_err         (par_err),
        .stp_err         (stp_err),
        .edge_bit_cnt_en (edge_bit_cnt_en),
        .dat_samp_en     (dat_samp_en),
        .start_check_en  (start_check_en),
        .deser_en        (deser_en),
        .par_chk_en      (par_chk_en),
        .stp_chk_en      (stp_chk_en),
        .data_valid      (data_valid),
        .frame_err       (frame_err)
    );

    // Free-running receiver clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    assign lastIdx = PAR_EN ? 4'd10 : 4'd9;

    // Upstream edge/bit counter model: runs while enabled, wraps the frame after its last bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_bit_cnt_en) begin
            if (edge_cnt == Prescale - 6'd1) begin
                edge_cnt <= '0;
                bit_cnt  <= (bit_cnt == lastIdx) ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
        end else begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_edge_bit_cnt_en"}, int'(edge_bit_cnt_en), 0);
        checkOutput({tag, "_dat_samp_en"},     int'(dat_samp_en),     0);
        checkOutput({tag, "_start_check_en"},  int'(start_check_en),  0);
        checkOutput({tag, "_deser_en"},        int'(deser_en),        0);
        checkOutput({tag, "_par_chk_en"},      int'(par_chk_en),      0);
        checkOutput({tag, "_stp_chk_en"},      int'(stp_chk_en),      0);
        checkOutput({tag, "_data_valid"},      int'(data_valid),      0);
        checkOutput({tag, "_frame_err"},       int'(frame_err),       0);
    endtask

    task automatic pushExp(input int kind, input int deser, input int par,
                           input int stp, input int start, input int stopIdx);
        exp_t e;
        e.kind    = kind;
        e.deser   = deser;
        e.par     = par;
        e.stp     = stp;
        e.start   = start;
        e.stopIdx = stopIdx;
        sbQ.push_back(e);
        pushed++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            RX_IN = 1'b1;
            @(negedge CLK);
        end
    endtask

    // Drives one full frame from a negedge; b2bIn skips idle detection, b2bOut pulls the line low on the last stop edge.
    task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parErr,
                                 input logic stpErr, input logic b2bIn, input logic b2bOut);
        int kind;
        kind = (stpErr || (parEn && parErr)) ? K_FERR : K_VALID;
        pushExp(kind, 8, parEn ? 1 : 0, 1, 1, parEn ? 10 : 9);
        PAR_EN  = parEn;
        par_err = parErr;
        stp_err = stpErr;
        if (!b2bIn) begin
            RX_IN = 1'b0;
            @(negedge CLK);
        end
        for (int e = 0; e < 8; e++) begin
            RX_IN = 1'b0;
            @(negedge CLK);
        end
        for (int b = 0; b < 8; b++) begin
            for (int e = 0; e < 8; e++) begin
                RX_IN = data[b];
                @(negedge CLK);
            end
        end
        if (parEn) begin
            for (int e = 0; e < 8; e++) begin
                RX_IN = ^data;
                @(negedge CLK);
            end
        end
        for (int e = 0; e < 8; e++) begin
            RX_IN = (b2bOut && e == 7) ? 1'b0 : 1'b1;
            @(negedge CLK);
        end
        par_err = 1'b0;
        stp_err = 1'b0;
        if (!b2bOut) begin
            RX_IN = 1'b1;
        end
    endtask

    // Monitor: tally strobes and compare against the scoreboard whenever a frame ends.
    always @(negedge CLK) begin
        exp_t e;
        int   got;
        if (data_valid || frame_err || (prevEn == 1 && !edge_bit_cnt_en)) begin
            got = data_valid ? K_VALID : (frame_err ? K_FERR : K_ABORT);
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_frame_end", got, -1);
            end else begin
                e = sbQ.pop_front();
                popped++;
                checkOutput("frame_kind",   got,    e.kind);
                checkOutput("deser_count",  nDeser, e.deser);
                checkOutput("par_chk_count", nPar,  e.par);
                checkOutput("stp_chk_count", nStp,  e.stp);
                checkOutput("start_check_count", nStart, e.start);
                if (got != K_ABORT) begin
                    checkOutput("pulse_exclusive", int'(data_valid && frame_err), 0);
                    checkOutput("latency_edge", prevEdge, 7);
                    checkOutput("latency_bit",  prevBit,  e.stopIdx);
                    checkOutput("stop_bit_idx", stpIdxSeen, e.stopIdx);
                end
            end
            nDeser     = 0;
            nPar       = 0;
            nStp       = 0;
            nStart     = 0;
            stpIdxSeen = -1;
        end
        if (deser_en)       nDeser++;
        if (par_chk_en)     nPar++;
        if (start_check_en) nStart++;
        if (stp_chk_en) begin
            nStp++;
            stpIdxSeen = int'(bit_cnt);
        end
        prevEn   = int'(edge_bit_cnt_en);
        prevEdge = int'(edge_cnt);
        prevBit  = int'(bit_cnt);
    end

    // Main directed sequence.
    initial begin
        RST          = 1'b1;
        RX_IN        = 1'b1;
        PAR_EN       = 1'b1;
        Prescale     = 6'd8;
        start_glitch = 1'b0;
        par_err      = 1'b0;
        stp_err      = 1'b0;
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        checkAllZero("reset");
        RST = 1'b1;
        idleCycles(3);

        $display("[TB] frame 0xA5 with parity");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        $display("[TB] start glitch");
        pushExp(K_ABORT, 0, 0, 0, 1, 0);
        RX_IN = 1'b0;
        @(negedge CLK);
        for (int e = 0; e < 8; e++) begin
            RX_IN        = (e < 2) ? 1'b0 : 1'b1;
            start_glitch = (e == 7);
            @(negedge CLK);
        end
        start_glitch = 1'b0;
        idleCycles(4);

        $display("[TB] parity error frame");
        applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        $display("[TB] stop error frame");
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(2);

        $display("[TB] no parity frame 0x3C");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        $display("[TB] no parity, stale par_err ignored");
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(3);

        $display("[TB] reset during data bit 4");
        pushExp(K_ABORT, 3, 0, 0, 1, 0);
        PAR_EN = 1'b1;
        RX_IN  = 1'b0;
        @(negedge CLK);
        for (int e = 0; e < 8; e++) begin
            RX_IN = 1'b0;
            @(negedge CLK);
        end
        for (int c = 0; c < 27; c++) begin
            RX_IN = c[0];
            @(negedge CLK);
        end
        #2 RST = 1'b0;
        #1 checkAllZero("mid_reset");
        @(negedge CLK);
        @(negedge CLK);
        RX_IN = 1'b1;
        RST   = 1'b1;
        idleCycles(3);

        $display("[TB] frame after reset");
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sbQ.size() != 0; i++) begin
            @(negedge CLK);
        end
        idleCycles(3);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        checkOutput("events_seen", popped, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
